// File: rtl/ccip_mmio_csr_responder_if.sv
// rtl/ccip_mmio_csr_responder_if.sv - CCI-P c0 MMIO request / c2 MMIO response bundle
interface ccip_mmio_csr_responder_if;
  logic        c0MmioRdValid;
  logic        c0MmioWrValid;
  logic [15:0] c0Address;
  logic        c0Length;
  logic [8:0]  c0Tid;
  logic [63:0] c0Data;
  logic        c2MmioRdValid;
  logic [8:0]  c2Tid;
  logic [63:0] c2Data;

  modport master (
    output c0MmioRdValid, c0MmioWrValid, c0Address, c0Length, c0Tid, c0Data,
    input  c2MmioRdValid, c2Tid, c2Data
  );

  modport slave (
    input  c0MmioRdValid, c0MmioWrValid, c0Address, c0Length, c0Tid, c0Data,
    output c2MmioRdValid, c2Tid, c2Data
  );
endinterface

// File: rtl/ccip_mmio_csr_responder.sv
// rtl/ccip_mmio_csr_responder.sv - AFU MMIO CSR block with two-stage read response pipeline
module ccip_mmio_csr_responder #(
  parameter logic [63:0] AFU_ID_L = 64'h0,
  parameter logic [63:0] AFU_ID_H = 64'h0
) (
  input  logic                              afu_clk,
  input  logic                              reset_n,
  ccip_mmio_csr_responder_if.slave          mmio,
  input  logic [63:0]                       sts_in,
  output logic [63:0]                       ctl_reg,
  output logic                              ctl_start
);

  localparam logic [63:0] DFH_VALUE = 64'h1000_0100_0000_0000;

  localparam logic [14:0] IDX_DFH     = 15'd0;
  localparam logic [14:0] IDX_AFU_L   = 15'd1;
  localparam logic [14:0] IDX_AFU_H   = 15'd2;
  localparam logic [14:0] IDX_SCRATCH = 15'd5;
  localparam logic [14:0] IDX_CTRL    = 15'd6;
  localparam logic [14:0] IDX_STATUS  = 15'd7;
  localparam logic [14:0] IDX_RDCNT   = 15'd8;
  localparam logic [14:0] IDX_WRCNT   = 15'd9;

  logic [63:0] scratchReg;
  logic [63:0] ctlReg;
  logic [63:0] rdCount;
  logic [63:0] wrCount;

  logic        rdReq;
  logic        wrReq;
  logic [14:0] reqIdx;
  logic        reqHalf;
  logic [63:0] rdSel;
  logic [63:0] scratchNext;
  logic [63:0] ctlNext;

  logic        s1Valid;
  logic [8:0]  s1Tid;
  logic        s1Len;
  logic        s1Half;
  logic [63:0] s1Data;

  assign rdReq   = mmio.c0MmioRdValid;
  assign wrReq   = mmio.c0MmioWrValid;
  assign reqIdx  = mmio.c0Address[15:1];
  assign reqHalf = mmio.c0Address[0];
  assign ctl_reg = ctlReg;

  // A 4 B write lands only in the addressed dword; the low 32 bits of c0Data carry it.
  function automatic logic [63:0] mergeWrite(input logic [63:0] oldVal, input logic [63:0] wrData,
                                             input logic len, input logic half);
    if (len)
      return wrData;
    else if (half)
      return {wrData[31:0], oldVal[31:0]};
    else
      return {oldVal[63:32], wrData[31:0]};
  endfunction

  assign scratchNext = mergeWrite(scratchReg, mmio.c0Data, mmio.c0Length, reqHalf);
  assign ctlNext     = mergeWrite(ctlReg, mmio.c0Data, mmio.c0Length, reqHalf) & ~64'h1;

  // Muxing from the current registers gives a same-cycle read the pre-write value;
  // RD_COUNT reports the count including the read being serviced.
  always_comb begin
    rdSel = 64'h0;
    case (reqIdx)
      IDX_DFH:     rdSel = DFH_VALUE;
      IDX_AFU_L:   rdSel = AFU_ID_L;
      IDX_AFU_H:   rdSel = AFU_ID_H;
      IDX_SCRATCH: rdSel = scratchReg;
      IDX_CTRL:    rdSel = ctlReg;
      IDX_STATUS:  rdSel = sts_in;
      IDX_RDCNT:   rdSel = rdCount + 64'd1;
      IDX_WRCNT:   rdSel = wrCount;
      default:     rdSel = 64'h0;
    endcase
  end

  always_ff @(posedge afu_clk or negedge reset_n) begin
    if (!reset_n) begin
      scratchReg <= 64'h0;
      ctlReg     <= 64'h0;
      ctl_start  <= 1'b0;
      rdCount    <= 64'h0;
      wrCount    <= 64'h0;
    end else begin
      ctl_start <= wrReq && (reqIdx == IDX_CTRL) && mmio.c0Data[0] &&
                   (mmio.c0Length || !reqHalf);
      if (wrReq && reqIdx == IDX_SCRATCH)
        scratchReg <= scratchNext;
      if (wrReq && reqIdx == IDX_CTRL)
        ctlReg <= ctlNext;
      // Clear beats increment on both counters.
      if (wrReq)
        rdCount <= 64'h0;
      else if (rdReq)
        rdCount <= rdCount + 64'd1;
      if (wrReq && reqIdx == IDX_WRCNT)
        wrCount <= 64'h0;
      else if (wrReq)
        wrCount <= wrCount + 64'd1;
    end
  end

  always_ff @(posedge afu_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid            <= 1'b0;
      s1Tid              <= 9'h0;
      s1Len              <= 1'b0;
      s1Half             <= 1'b0;
      s1Data             <= 64'h0;
      mmio.c2MmioRdValid <= 1'b0;
      mmio.c2Tid         <= 9'h0;
      mmio.c2Data        <= 64'h0;
    end else begin
      s1Valid <= rdReq;
      if (rdReq) begin
        s1Tid  <= mmio.c0Tid;
        s1Len  <= mmio.c0Length;
        s1Half <= reqHalf;
        s1Data <= rdSel;
      end
      mmio.c2MmioRdValid <= s1Valid;
      if (s1Valid) begin
        mmio.c2Tid <= s1Tid;
        if (s1Len)
          mmio.c2Data <= s1Data;
        else if (s1Half)
          mmio.c2Data <= {s1Data[63:32], s1Data[63:32]};
        else
          mmio.c2Data <= {s1Data[31:0], s1Data[31:0]};
      end
    end
  end

endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// tb/tb_ccip_mmio_csr_responder.sv - directed self-checking bench for the MMIO CSR responder
module tb_ccip_mmio_csr_responder;
  localparam logic [63:0] AFU_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] AFU_H = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] STS   = 64'hA5A5_0000_1234_5678;

  logic        afu_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] sts_in;
  logic [63:0] ctl_reg;
  logic        ctl_start;
  int          cmpCount = 0;
  int          misCount = 0;

  ccip_mmio_csr_responder_if bus ();

  ccip_mmio_csr_responder #(.AFU_ID_L(AFU_L), .AFU_ID_H(AFU_H)) dut (
    .afu_clk   (afu_clk),
    .reset_n   (reset_n),
    .mmio      (bus.slave),
    .sts_in    (sts_in),
    .ctl_reg   (ctl_reg),
    .ctl_start (ctl_start)
  );

  always #5 afu_clk = ~afu_clk;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmpCount++;
    if (obs !== exp) begin
      misCount++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic mmioWrite(input logic [15:0] addr, input logic len, input logic [63:0] data);
    bus.c0MmioWrValid = 1'b1;
    bus.c0Address     = addr;
    bus.c0Length      = len;
    bus.c0Data        = data;
    @(posedge afu_clk); #1;
    bus.c0MmioWrValid = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [15:0] addr, input logic len,
                           input logic [8:0] tid, input logic [63:0] exp);
    bus.c0MmioRdValid = 1'b1;
    bus.c0Address     = addr;
    bus.c0Length      = len;
    bus.c0Tid         = tid;
    @(posedge afu_clk); #1;
    bus.c0MmioRdValid = 1'b0;
    checkValue({tag, ".n1valid"}, {63'h0, bus.c2MmioRdValid}, 64'h0);
    @(posedge afu_clk); #1;
    checkValue({tag, ".valid"}, {63'h0, bus.c2MmioRdValid}, 64'h1);
    checkValue({tag, ".tid"}, {55'h0, bus.c2Tid}, {55'h0, tid});
    checkValue({tag, ".data"}, bus.c2Data, exp);
  endtask

  logic [15:0] b2bAddr [4];
  logic [63:0] b2bExp  [4];

  initial begin
    bus.c0MmioRdValid = 1'b0;
    bus.c0MmioWrValid = 1'b0;
    bus.c0Address     = 16'h0;
    bus.c0Length      = 1'b0;
    bus.c0Tid         = 9'h0;
    bus.c0Data        = 64'h0;
    sts_in            = STS;

    repeat (3) @(posedge afu_clk);
    #1;
    checkValue("rst.c2valid", {63'h0, bus.c2MmioRdValid}, 64'h0);
    checkValue("rst.c2tid", {55'h0, bus.c2Tid}, 64'h0);
    checkValue("rst.c2data", bus.c2Data, 64'h0);
    checkValue("rst.ctlreg", ctl_reg, 64'h0);
    checkValue("rst.ctlstart", {63'h0, ctl_start}, 64'h0);
    reset_n = 1'b1;
    @(posedge afu_clk); #1;

    readCheck("dfh", 16'h0000, 1'b1, 9'h1A5, 64'h1000_0100_0000_0000);
    readCheck("afuh", 16'h0004, 1'b1, 9'h002, AFU_H);
    readCheck("rsvd18", 16'h0006, 1'b1, 9'h003, 64'h0);

    mmioWrite(16'h000A, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
    readCheck("scr.lo4", 16'h000A, 1'b0, 9'h004, 64'hCAFE_F00D_CAFE_F00D);
    readCheck("scr.hi4", 16'h000B, 1'b0, 9'h005, 64'hDEAD_BEEF_DEAD_BEEF);
    mmioWrite(16'h000B, 1'b0, 64'h0000_0000_1234_5678);
    readCheck("scr.merge", 16'h000B, 1'b1, 9'h006, 64'h1234_5678_CAFE_F00D);

    mmioWrite(16'h000C, 1'b1, 64'h5);
    checkValue("ctl.pulse", {63'h0, ctl_start}, 64'h1);
    checkValue("ctl.reg", ctl_reg, 64'h4);
    @(posedge afu_clk); #1;
    checkValue("ctl.pulseend", {63'h0, ctl_start}, 64'h0);
    mmioWrite(16'h000D, 1'b0, 64'h1);
    checkValue("ctl.hinopulse", {63'h0, ctl_start}, 64'h0);
    checkValue("ctl.hireg", ctl_reg, 64'h0000_0001_0000_0004);

    // Last write cleared RD_COUNT; the fourth read sees three prior plus itself.
    b2bAddr[0] = 16'h0002; b2bExp[0] = AFU_L;
    b2bAddr[1] = 16'h000E; b2bExp[1] = STS;
    b2bAddr[2] = 16'h0040; b2bExp[2] = 64'h0;
    b2bAddr[3] = 16'h0010; b2bExp[3] = 64'd4;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        bus.c0MmioRdValid = 1'b1;
        bus.c0Address     = b2bAddr[i];
        bus.c0Length      = 1'b1;
        bus.c0Tid         = 9'(i + 1);
      end else begin
        bus.c0MmioRdValid = 1'b0;
      end
      if (i >= 2) begin
        checkValue($sformatf("b2b%0d.valid", i - 1), {63'h0, bus.c2MmioRdValid}, 64'h1);
        checkValue($sformatf("b2b%0d.tid", i - 1), {55'h0, bus.c2Tid}, 64'(i - 1));
        checkValue($sformatf("b2b%0d.data", i - 1), bus.c2Data, b2bExp[i - 2]);
      end
      @(posedge afu_clk); #1;
    end

    readCheck("wrcnt", 16'h0012, 1'b1, 9'h010, 64'd4);
    mmioWrite(16'h0012, 1'b1, 64'hFFFF);
    readCheck("wrcnt.clr", 16'h0012, 1'b1, 9'h011, 64'd0);
    mmioWrite(16'h0040, 1'b1, 64'h1111);
    readCheck("wrcnt.unmapped", 16'h0012, 1'b1, 9'h012, 64'd1);
    readCheck("scr.unchanged", 16'h000A, 1'b1, 9'h013, 64'h1234_5678_CAFE_F00D);

    bus.c0MmioRdValid = 1'b1;
    bus.c0Address     = 16'h0010;
    bus.c0Length      = 1'b1;
    bus.c0Tid         = 9'h055;
    @(posedge afu_clk); #1;
    bus.c0MmioRdValid = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge afu_clk); #1;
      checkValue($sformatf("flush%0d.valid", i), {63'h0, bus.c2MmioRdValid}, 64'h0);
    end
    checkValue("flush.ctlreg", ctl_reg, 64'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge afu_clk); #1;
      checkValue($sformatf("post%0d.valid", i), {63'h0, bus.c2MmioRdValid}, 64'h0);
    end
    readCheck("rdcnt.post", 16'h0010, 1'b1, 9'h0AA, 64'd1);
    readCheck("scr.post", 16'h000A, 1'b1, 9'h0AB, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, misCount);
    $finish;
  end
endmodule
